// File: rtl/instr_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_pkg
// Shared definitions for the loadable instruction memory:
//   - ldr_state_e   : boot-loader FSM state encodings
//   - DEFAULT_INSTR : instruction returned for unmapped/unwritten words. The CPU
//                     decode stage imports the same constant so both agree on
//                     what an "empty" fetch looks like.
//   - bytes_per_word: number of loader bytes needed to build one word
// -----------------------------------------------------------------------------
package instr_mem_loader_pkg;

    typedef enum logic [1:0] {
        LDR_IDLE    = 2'd0,
        LDR_COLLECT = 2'd1,
        LDR_WRITE   = 2'd2,
        LDR_DONE    = 2'd3
    } ldr_state_e;

    // Widest supported instruction word; DEFAULT_INSTR is sliced from this.
    localparam int unsigned   MAX_DATA_WIDTH = 32'd32;
    localparam logic [31:0]   DEFAULT_INSTR  = 32'h0000_0000;

    // ceil(width/8): bytes streamed in per instruction word.
    function automatic int unsigned bytes_per_word(input int unsigned width);
        return (width + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/instr_word_assembler.sv
// -----------------------------------------------------------------------------
// instr_word_assembler
// Collects loader bytes little-endian into one instruction word.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset
//   clear_i     : restart assembly at byte 0 (start of a new load)
//   byte_en_i   : a byte handshake happens this cycle
//   byte_i      : loader byte
//   word_o      : assembled word (byte 0 in bits [7:0]); exact once the
//                 cycle following word_done_o is reached
//   word_done_o : combinational strobe, high on the handshake of the last byte
//                 of a word so the FSM can move to its write state on the very
//                 edge that captures that byte
// -----------------------------------------------------------------------------
module instr_word_assembler
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 28,
    parameter int unsigned BYTES_PER_WORD = bytes_per_word(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  byte_en_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_done_o
);

    localparam int unsigned SHIFT_W  = BYTES_PER_WORD * 8;
    localparam logic [1:0]  LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [1:0]         idx_q, idx_d;

    // Next-state: place the byte at its lane and advance the byte index.
    always_comb begin
        shift_d     = shift_q;
        idx_d       = idx_q;
        word_done_o = 1'b0;
        if (clear_i) begin
            idx_d = 2'd0;
        end else if (byte_en_i) begin
            for (int b = 0; b < int'(BYTES_PER_WORD); b++) begin
                if (idx_q == 2'(b)) begin
                    shift_d[b*8 +: 8] = byte_i;
                end else begin
                    shift_d[b*8 +: 8] = shift_q[b*8 +: 8];
                end
            end
            if (idx_q == LAST_IDX) begin
                idx_d       = 2'd0;
                word_done_o = 1'b1;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Byte lanes and byte index registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            idx_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    // Bits above DATA_WIDTH in the last byte are dropped here.
    assign word_o = shift_q[DATA_WIDTH-1:0];

    generate
        if (SHIFT_W > DATA_WIDTH) begin : g_pad
            logic unused_pad_s;
            assign unused_pad_s = ^shift_q[SHIFT_W-1:DATA_WIDTH];
        end
    endgenerate

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Loadable instruction RAM for the CPU fetch stage with a byte-stream boot
// loader.
//   Clock / Reset        : clock, asynchronous active-low reset
//   iAddress             : fetch address (16 bits)
//   oInstruction         : registered fetch data, DEFAULT_WORD when the word is
//                          out of range, never written, or a load is running
//   oInstructionValid    : oInstruction belongs to last cycle's iAddress
//   iLoadStart           : one-cycle pulse that starts a load (IDLE only)
//   iLoadLength          : words to load, clamped to the RAM depth
//   iByte / iByteValid   : loader byte stream (valid/ready handshake)
//   oByteReady           : loader accepts a byte this cycle
//   oLoading             : load in progress, used as the CPU stall
//   oLoadDone            : one-cycle pulse at the end of a load
//   oWordCount           : words written by the current/last load
// -----------------------------------------------------------------------------
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH   = 28,
    parameter int unsigned            ADDR_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0]  DEFAULT_WORD = DEFAULT_INSTR[DATA_WIDTH-1:0]
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [15:0]           iAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oInstructionValid,
    input  logic                  iLoadStart,
    input  logic [ADDR_WIDTH:0]   iLoadLength,
    input  logic [7:0]            iByte,
    input  logic                  iByteValid,
    output logic                  oByteReady,
    output logic                  oLoading,
    output logic                  oLoadDone,
    output logic [ADDR_WIDTH:0]   oWordCount
);

    localparam int unsigned         BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
    localparam int unsigned         DEPTH          = 32'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L        = (ADDR_WIDTH + 1)'(DEPTH);

    ldr_state_e             state_q, state_d;
    logic [ADDR_WIDTH:0]    len_q, len_d;
    logic [ADDR_WIDTH:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0]       written_q, written_d;
    logic [DATA_WIDTH-1:0]  instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic [DATA_WIDTH-1:0]  ram_q [DEPTH];

    logic [ADDR_WIDTH:0]    len_clamp_s;
    logic                   asm_clear_s;
    logic                   asm_en_s;
    logic [DATA_WIDTH-1:0]  asm_word_s;
    logic                   asm_done_s;
    logic                   we_s;
    logic [ADDR_WIDTH-1:0]  waddr_s;
    logic [ADDR_WIDTH-1:0]  raddr_s;
    logic                   in_range_s;
    logic                   fetch_hit_s;

    // Byte collection runs in the assembler; the FSM only gates it.
    assign asm_clear_s = (state_q == LDR_IDLE) && iLoadStart;
    assign asm_en_s    = (state_q == LDR_COLLECT) && iByteValid;

    instr_word_assembler #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_asm (
        .clk_i       (Clock),
        .rst_ni      (Reset),
        .clear_i     (asm_clear_s),
        .byte_en_i   (asm_en_s),
        .byte_i      (iByte),
        .word_o      (asm_word_s),
        .word_done_o (asm_done_s)
    );

    // Requested length limited to the RAM depth so the write address never wraps.
    always_comb begin
        if (iLoadLength > DEPTH_L) begin
            len_clamp_s = DEPTH_L;
        end else begin
            len_clamp_s = iLoadLength;
        end
    end

    // Loader FSM next-state logic.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        case (state_q)
            LDR_IDLE: begin
                if (iLoadStart) begin
                    len_d = len_clamp_s;
                    cnt_d = '0;
                    if (len_clamp_s == '0) begin
                        state_d = LDR_DONE;
                    end else begin
                        state_d = LDR_COLLECT;
                    end
                end else begin
                    state_d = LDR_IDLE;
                end
            end
            LDR_COLLECT: begin
                if (asm_done_s) begin
                    state_d = LDR_WRITE;
                end else begin
                    state_d = LDR_COLLECT;
                end
            end
            LDR_WRITE: begin
                cnt_d = cnt_q + (ADDR_WIDTH + 1)'(1);
                if (cnt_d == len_q) begin
                    state_d = LDR_DONE;
                end else begin
                    state_d = LDR_COLLECT;
                end
            end
            LDR_DONE: begin
                state_d = LDR_IDLE;
            end
            default: begin
                state_d = LDR_IDLE;
            end
        endcase
    end

    // Loader FSM, latched length and word counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= LDR_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // The word counter doubles as the write address: both start at 0 and step
    // together, and the clamped length keeps it below DEPTH on every write.
    assign we_s    = (state_q == LDR_WRITE);
    assign waddr_s = cnt_q[ADDR_WIDTH-1:0];

    // Written-bit update: only the word stored this cycle changes.
    always_comb begin
        written_d = written_q;
        if (we_s) begin
            written_d[waddr_s] = 1'b1;
        end else begin
            written_d = written_q;
        end
    end

    // Written bits are reset so stale RAM contents are never fetched after reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            written_q <= '0;
        end else begin
            written_q <= written_d;
        end
    end

    // RAM array write port; contents deliberately survive reset.
    always_ff @(posedge Clock) begin
        if (we_s) begin
            ram_q[waddr_s] <= asm_word_s;
        end
    end

    assign raddr_s     = iAddress[ADDR_WIDTH-1:0];
    assign in_range_s  = ((iAddress >> ADDR_WIDTH) == 16'd0);
    assign fetch_hit_s = in_range_s && written_q[raddr_s] && (state_q == LDR_IDLE);

    // Fetch data select and validity for the output register.
    always_comb begin
        if (fetch_hit_s) begin
            instr_d = ram_q[raddr_s];
        end else begin
            instr_d = DEFAULT_WORD;
        end
        valid_d = (state_q == LDR_IDLE);
    end

    // Fetch output register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            instr_q <= DEFAULT_WORD;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign oInstruction      = instr_q;
    assign oInstructionValid = valid_q;
    assign oByteReady        = (state_q == LDR_COLLECT);
    assign oLoading          = (state_q != LDR_IDLE);
    assign oLoadDone         = (state_q == LDR_DONE);
    assign oWordCount        = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    localparam int DW    = 28;
    localparam int AW    = 8;
    localparam int BPW   = 4;
    localparam int DEPTH = 256;
    localparam logic [DW-1:0] DEF = 28'h0;

    localparam int DW2    = 16;
    localparam int AW2    = 4;
    localparam int DEPTH2 = 16;
    localparam logic [15:0] DEF2 = 16'hBEEF;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    logic [15:0]   iAddress;
    logic [DW-1:0] oInstruction;
    logic          oInstructionValid;
    logic          iLoadStart;
    logic [AW:0]   iLoadLength;
    logic [7:0]    iByte;
    logic          iByteValid;
    logic          oByteReady, oLoading, oLoadDone;
    logic [AW:0]   oWordCount;

    logic [15:0]   d2_addr;
    logic [15:0]   d2_instr;
    logic          d2_ivalid, d2_start, d2_bvalid, d2_bready, d2_loading, d2_done;
    logic [AW2:0]  d2_len, d2_count;
    logic [7:0]    d2_byte;

    instr_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEFAULT_WORD(DEF)) dut (
        .Clock(Clock), .Reset(Reset), .iAddress(iAddress), .oInstruction(oInstruction),
        .oInstructionValid(oInstructionValid), .iLoadStart(iLoadStart),
        .iLoadLength(iLoadLength), .iByte(iByte), .iByteValid(iByteValid),
        .oByteReady(oByteReady), .oLoading(oLoading), .oLoadDone(oLoadDone),
        .oWordCount(oWordCount)
    );

    instr_mem_loader #(.DATA_WIDTH(DW2), .ADDR_WIDTH(AW2), .DEFAULT_WORD(DEF2)) dut2 (
        .Clock(Clock), .Reset(Reset), .iAddress(d2_addr), .oInstruction(d2_instr),
        .oInstructionValid(d2_ivalid), .iLoadStart(d2_start),
        .iLoadLength(d2_len), .iByte(d2_byte), .iByteValid(d2_bvalid),
        .oByteReady(d2_bready), .oLoading(d2_loading), .oLoadDone(d2_done),
        .oWordCount(d2_count)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_mem [DEPTH];
    bit            model_wr  [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [15:0]   exp2_q [$];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [DW-1:0] model_read(input int addr);
        if (addr < DEPTH && model_wr[addr]) return model_mem[addr];
        return DEF;
    endfunction

    // Fetch one address; expected value pushed at drive time, popped at output.
    task automatic fetch_check(input int addr, input logic [DW-1:0] expv, input string name);
        logic [DW-1:0] e;
        iAddress = 16'(addr);
        exp_q.push_back(expv);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (oInstruction !== e) begin
            errors++;
            $display("FAIL %s addr=%0d oInstruction got %h want %h", name, addr, oInstruction, e);
        end
        checks++;
        if (oInstructionValid !== 1'b1) begin
            errors++;
            $display("FAIL %s addr=%0d oInstructionValid got %b want 1", name, addr, oInstructionValid);
        end
    endtask

    // Run one load; poke_at >= 0 pulses iLoadStart while that byte is offered.
    task automatic do_load(input int len, input logic [7:0] bytes[$], input bit rnd,
                           input int poke_at, input string name);
        int eff, bi, inword, budget, nbytes;
        bit hs, seen;
        logic [31:0] w32;
        eff    = (len > DEPTH) ? DEPTH : len;
        nbytes = bytes.size();
        iLoadLength = 9'(len);
        iLoadStart  = 1'b1;
        tick();
        iLoadStart = 1'b0;
        checks++;
        if (oLoading !== 1'b1) begin
            errors++;
            $display("FAIL %s oLoading after start got %b want 1", name, oLoading);
        end
        if (eff > 0) begin
            checks++;
            if (oByteReady !== 1'b1) begin
                errors++;
                $display("FAIL %s oByteReady after start got %b want 1", name, oByteReady);
            end
        end
        bi = 0; inword = 0; budget = 0;
        while (bi < nbytes) begin
            iByte      = bytes[bi];
            iByteValid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            iLoadStart = (bi == poke_at) ? 1'b1 : 1'b0;
            iLoadLength = (bi == poke_at) ? 9'd1 : 9'(len);
            hs = iByteValid && oByteReady;
            tick();
            iLoadStart = 1'b0;
            if (hs) begin
                bi++;
                inword++;
                if (inword == BPW) begin
                    inword = 0;
                    checks++;
                    if (oByteReady !== 1'b0) begin
                        errors++;
                        $display("FAIL %s oByteReady in WRITE got %b want 0", name, oByteReady);
                    end
                end
            end
            budget++;
            if (budget > 20000) begin
                checks++;
                errors++;
                $display("FAIL %s byte stream timeout at byte %0d", name, bi);
                break;
            end
        end
        iByteValid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            if (oLoadDone === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s oLoadDone got 0 want 1 within bound", name);
        end
        checks++;
        if (oWordCount !== 9'(eff)) begin
            errors++;
            $display("FAIL %s oWordCount got %0d want %0d", name, oWordCount, eff);
        end
        tick();
        checks++;
        if (oLoadDone !== 1'b0 || oLoading !== 1'b0) begin
            errors++;
            $display("FAIL %s after done oLoadDone=%b oLoading=%b want 0 0", name, oLoadDone, oLoading);
        end
        for (int w = 0; w < eff; w++) begin
            w32 = '0;
            for (int j = 0; j < BPW; j++) w32[j*8 +: 8] = bytes[w*BPW + j];
            model_mem[w] = w32[DW-1:0];
            model_wr[w]  = 1'b1;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        iAddress = 16'd0; iLoadStart = 1'b0; iLoadLength = '0; iByte = 8'd0; iByteValid = 1'b0;
        d2_addr = 16'd0; d2_start = 1'b0; d2_len = '0; d2_byte = 8'd0; d2_bvalid = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_wr[i] = 1'b0;
        tick(); tick();
        checks++;
        if (oInstruction !== DEF || oInstructionValid !== 1'b0 || oByteReady !== 1'b0 ||
            oLoading !== 1'b0 || oLoadDone !== 1'b0 || oWordCount !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got instr=%h v=%b rdy=%b ld=%b dn=%b cnt=%0d want all 0",
                     oInstruction, oInstructionValid, oByteReady, oLoading, oLoadDone, oWordCount);
        end
        @(negedge Clock);
        Reset = 1'b1;
        fetch_check(0, DEF, "reset_fetch0");
        fetch_check(5, DEF, "reset_fetch5");
        fetch_check(255, DEF, "reset_fetch255");
    endtask

    task automatic test_three_word();
        logic [7:0] b[$];
        b = '{8'h67, 8'h45, 8'h23, 8'h01, 8'hF0, 8'hDE, 8'hBC, 8'h0A, 8'hA0, 8'h0F, 8'h00, 8'h00};
        do_load(3, b, 1'b0, -1, "three_word");
        fetch_check(0, 28'h1234567, "three_word_rd0");
        fetch_check(1, 28'hABCDEF0, "three_word_rd1");
        fetch_check(2, 28'h0000FA0, "three_word_rd2");
        fetch_check(3, DEF, "three_word_rd3");
    endtask

    task automatic test_backpressure();
        logic [7:0] b[$];
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'hF5};
        do_load(2, b, 1'b1, -1, "backpressure");
        fetch_check(0, 28'h4332211, "trunc_rd0");
        fetch_check(1, 28'h5332211, "trunc_rd1");
        fetch_check(2, 28'h0000FA0, "keep_rd2");
    endtask

    task automatic test_length_bounds();
        logic [7:0] b[$];
        b = {};
        do_load(0, b, 1'b0, -1, "len0");
        fetch_check(0, 28'h4332211, "len0_nowrite");
        for (int w = 0; w < DEPTH; w++)
            for (int j = 0; j < BPW; j++) b.push_back(8'(w * 5 + j * 17 + 3));
        do_load(300, b, 1'b0, -1, "len300");
        fetch_check(0, model_read(0), "len300_rd0");
        fetch_check(127, model_read(127), "len300_rd127");
        fetch_check(255, model_read(255), "len300_rd255");
        fetch_check(256, DEF, "oob_256");
    endtask

    task automatic test_reset_midload();
        int bi, budget;
        bit hs;
        iLoadLength = 9'd5;
        iLoadStart  = 1'b1;
        tick();
        iLoadStart = 1'b0;
        bi = 0; budget = 0;
        while (bi < 8 && budget < 100) begin
            iByte = 8'(8'hA0 + bi);
            iByteValid = 1'b1;
            hs = oByteReady;
            tick();
            if (hs) bi++;
            budget++;
        end
        iByteValid = 1'b0;
        tick();
        checks++;
        if (oWordCount !== 9'd2) begin
            errors++;
            $display("FAIL midload_count got %0d want 2", oWordCount);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (oInstruction !== DEF || oInstructionValid !== 1'b0 || oByteReady !== 1'b0 ||
            oLoading !== 1'b0 || oLoadDone !== 1'b0 || oWordCount !== 9'd0) begin
            errors++;
            $display("FAIL midload_reset got instr=%h v=%b rdy=%b ld=%b dn=%b cnt=%0d want all 0",
                     oInstruction, oInstructionValid, oByteReady, oLoading, oLoadDone, oWordCount);
        end
        for (int i = 0; i < DEPTH; i++) model_wr[i] = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        fetch_check(0, DEF, "midload_rd0");
        fetch_check(1, DEF, "midload_rd1");
    endtask

    task automatic test_ignored_start();
        logic [7:0] b[$];
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        do_load(2, b, 1'b0, 2, "ignored_start");
        fetch_check(0, 28'h4030201, "ignored_rd0");
        fetch_check(1, 28'h8070605, "ignored_rd1");
    endtask

    task automatic test_param_sweep();
        logic [15:0] m2 [DEPTH2];
        logic [15:0] e;
        int bi, budget;
        bit hs, seen;
        for (int w = 0; w < DEPTH2; w++) m2[w] = {8'(w * 16 + 2), 8'(w * 16 + 1)};
        d2_len = 5'd20;
        d2_start = 1'b1;
        tick();
        d2_start = 1'b0;
        bi = 0; budget = 0;
        while (bi < DEPTH2 * 2 && budget < 1000) begin
            d2_byte   = (bi % 2 == 0) ? m2[bi / 2][7:0] : m2[bi / 2][15:8];
            d2_bvalid = 1'b1;
            hs = d2_bready;
            tick();
            if (hs) bi++;
            budget++;
        end
        d2_bvalid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            if (d2_done === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen || d2_count !== 5'd16) begin
            errors++;
            $display("FAIL sweep_done got done=%b count=%0d want 1 16", seen, d2_count);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            int a;
            a = (k == 0) ? 0 : (k == 1) ? 7 : (k == 2) ? 15 : (k == 3) ? 16 : 300;
            d2_addr = 16'(a);
            if (k == 0) exp2_q.push_back(16'h0201);
            else if (a < DEPTH2) exp2_q.push_back(m2[a]);
            else exp2_q.push_back(DEF2);
            tick();
            e = exp2_q.pop_front();
            checks++;
            if (d2_instr !== e || d2_ivalid !== 1'b1) begin
                errors++;
                $display("FAIL sweep_rd addr=%0d got %h v=%b want %h v=1", a, d2_instr, d2_ivalid, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_three_word();
        test_backpressure();
        test_length_bounds();
        test_reset_midload();
        test_ignored_start();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Parametrised, loadable successor to the fixed program ROM that feeds the CPU fetch stage. It holds `2**ADDR_WIDTH` instruction words in on-chip RAM with a registered read port and returns `DEFAULT_WORD` for out-of-range or never-written locations. A byte-stream boot loader with a valid/ready handshake fills the RAM at run time. While a load is in progress, `oLoading` holds the CPU stalled.

## Interface

Parameters:

- `DATA_WIDTH`, default 28: instruction word width, from 1 to 32.
- `ADDR_WIDTH`, default 8: RAM depth is `2**ADDR_WIDTH` words.
- `DEFAULT_WORD`, default `28'h0`: word returned for unmapped or unwritten addresses and during a load.
- `BYTES_PER_WORD`, local: `ceil(DATA_WIDTH/8)`, so 4 at the default width.

Ports (name, direction, width, meaning):

- `Clock`, in, 1: the single clock.
- `Reset`, in, 1: asynchronous, active-low reset.
- `iAddress`, in, 16: fetch address.
- `oInstruction`, out, `DATA_WIDTH`: registered fetch data.
- `oInstructionValid`, out, 1: `oInstruction` corresponds to the `iAddress` of the previous cycle.
- `iLoadStart`, in, 1: single-cycle pulse that begins a load.
- `iLoadLength`, in, `ADDR_WIDTH+1`: number of words to load, sampled on `iLoadStart`.
- `iByte`, in, 8: loader data byte.
- `iByteValid`, in, 1: `iByte` is valid.
- `oByteReady`, out, 1: loader can accept a byte this cycle.
- `oLoading`, out, 1: high from the cycle after `iLoadStart` through the `DONE` state; used as the CPU stall.
- `oLoadDone`, out, 1: one-cycle pulse when a load finishes.
- `oWordCount`, out, `ADDR_WIDTH+1`: number of words written in the current or last load.

## Operation

- **Fetch path:**
  - Each cycle, register `RAM[iAddress]` into `oInstruction` when all three hold: `iAddress < 2**ADDR_WIDTH`, that word's written bit is set, and the FSM is `IDLE`.
  - Otherwise register `DEFAULT_WORD`.
  - `oInstructionValid` is 1 in the cycle after any `IDLE` cycle. It is 0 while `oLoading` is high and in the first cycle after reset.
- **Written bits:** one bit per word, all cleared by reset. The RAM array itself is not reset.
- **Loader FSM states:** `IDLE`, `COLLECT`, `WRITE`, `DONE`.
  - `IDLE`, on `iLoadStart`:
    - Latch the length.
    - Clear the word address, the byte index and `oWordCount`.
    - Go to `COLLECT`, or go straight to `DONE` if the length is 0.
  - `COLLECT`:
    - `oByteReady` is 1.
    - On each handshake (`iByteValid && oByteReady`), shift in the byte little-endian: the first byte goes to bits [7:0].
    - On the `BYTES_PER_WORD`-th byte, go to `WRITE`.
  - `WRITE`:
    - `oByteReady` is 0.
    - Write the assembled word, truncated to `DATA_WIDTH`. Bits above `DATA_WIDTH` in the last byte are discarded.
    - Set the word's written bit, increment the word address and `oWordCount`.
    - If `oWordCount+1 == length`, go to `DONE`; otherwise go to `COLLECT`.
  - `DONE`: assert `oLoadDone` for one cycle, then go to `IDLE`.
- **Boundary cases:**
  - A length above `2**ADDR_WIDTH` is clamped to `2**ADDR_WIDTH`. The word address does not wrap.
  - `iLoadStart` outside `IDLE` is ignored.
  - `iByteValid` while `oByteReady` is 0 is not consumed; the byte must be held by the source.
  - Words not written by a load keep their previous contents and their previous written bits.
- **Reset, including mid-load:**
  - FSM returns to `IDLE`.
  - `oInstruction` = `DEFAULT_WORD`.
  - `oInstructionValid`, `oByteReady`, `oLoading`, `oLoadDone` and `oWordCount` are all 0.
  - All written bits are cleared, so every fetch returns `DEFAULT_WORD` until the next load.

## Timing

- **Fetch latency:** 1 cycle, address to `oInstruction`.
- **Load throughput:** `BYTES_PER_WORD+1` cycles per word at full handshake rate. A written word is fetchable after `DONE`.
- **`oLoading`:**
  - Rises the cycle after `iLoadStart`.
  - Falls with the FSM's return to `IDLE`, the cycle after `oLoadDone`.
- **Fetch recovery:** the first valid fetch appears 1 cycle after `oLoading` falls.
- **Load start:** `iLoadStart` with length L ≥ 1 raises `oByteReady` in the next cycle.
- **Load end:** the last byte is followed by `WRITE`, then `DONE`; `oLoadDone` is high 2 cycles after the last handshake.

## Structure

- **Shared definitions header:**
  - Loader state encodings `LDR_IDLE`, `LDR_COLLECT`, `LDR_WRITE`, `LDR_DONE`.
  - The default instruction constant, so the CPU decode and this block agree on it.
- **Sub-module `instr_word_assembler`:** byte shift register plus byte-index counter. Outputs the assembled word and a word-complete strobe. Reset is asynchronous, active-low.
- **Top level:** contains the FSM, the RAM array, the written-bit vector and the fetch register.

## Test plan

1. **Reset-only fetch:** reset, then fetch addresses 0, 5 and 255 → `oInstruction` = `DEFAULT_WORD` each time; `oInstructionValid` = 1 from the second cycle after reset release.
2. **Three-word load and readback:**
   - Stimulus: `iLoadLength`=3, then 12 bytes at full rate, giving words `28'h1234567`, `28'hABCDEF0`, `28'h0000FA0`.
   - Response: `oLoadDone` pulses once and `oWordCount`=3.
   - Fetching addresses 0–2 returns the three words with 1-cycle latency; address 3 returns `DEFAULT_WORD`.
3. **Backpressure and truncation:**
   - Toggle `iByteValid` randomly during a load. Use last byte `8'hF5`, giving top nibble F → stored bits [27:24] = 5.
   - `oByteReady` = 0 in every `WRITE` cycle.
4. **Length boundaries:**
   - `iLoadLength`=0 → `oLoadDone` in the next `DONE` cycle, with no writes.
   - `iLoadLength`=300 with `ADDR_WIDTH`=8 → exactly 256 words are written, and the load ends with `oWordCount`=256.
5. **Reset mid-load and ignored start:**
   - Assert `Reset` after the 2nd word of a 5-word load → all outputs 0 or `DEFAULT_WORD`, and fetch of address 0 returns `DEFAULT_WORD`.
   - `iLoadStart` pulsed during `COLLECT` → no restart.
6. **Parameter sweep:** `DATA_WIDTH`=16 and `ADDR_WIDTH`=4 → 2 bytes per word, out-of-range address 16 returns `DEFAULT_WORD`, and scenarios 2–5 pass.
